// File: rtl/sar_search.sv
// Successive-approximation search over the full signed WIDTH-bit range, driven
// by an external comparator that reports A vs. Trial through Gt/Eq/Lt flags.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             Gt,
    input  logic             Eq,
    input  logic             Lt,
    output logic [WIDTH-1:0] Trial,
    output logic [WIDTH-1:0] Result,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, TEST, VERIFY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] code;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] code_upd;
    logic             one_hot;

    // Offset-binary code: flipping the MSB maps it onto two's complement.
    assign Trial     = code ^ MSB;
    assign one_hot   = ({Gt, Eq, Lt} == 3'b100) || ({Gt, Eq, Lt} == 3'b010) ||
                       ({Gt, Eq, Lt} == 3'b001);
    assign dbg_state = state;

    // Resolve bit k from the comparator, then tentatively set the next bit down.
    always_comb begin
        code_upd = code;
        if (Lt)
            code_upd[k] = 1'b0;
        if (k != '0)
            code_upd[k - KW'(1)] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            code   <= '0;
            k      <= '0;
            Result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        code  <= MSB;
                        k     <= KW'(WIDTH - 1);
                        found <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= TEST;
                    end
                end
                TEST: begin
                    if (!one_hot) begin
                        err    <= 1'b1;
                        found  <= 1'b0;
                        Result <= Trial;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (Eq) begin
                        found  <= 1'b1;
                        Result <= Trial;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        code <= code_upd;
                        if (k != '0)
                            k <= k - KW'(1);
                        else
                            state <= VERIFY;
                    end
                end
                VERIFY: begin
                    Result <= Trial;
                    found  <= Eq;
                    err    <= !one_hot;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter: WIDTH, default `WIDTH (4, from define.h); word width of trial and result.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset is asynchronous and active-low.
REQ-004 start  input  1  single-cycle request to begin a search; honoured only in IDLE.
REQ-005 Gt  input  1  external comparator flag: unknown A > Trial (signed).
REQ-006 Eq  input  1  external comparator flag: A == Trial.
REQ-007 Lt  input  1  external comparator flag: A < Trial (signed).
REQ-008 Trial  output  WIDTH  signed trial value driven to the comparator B input.
REQ-009 Result  output  WIDTH  signed search result; valid from done and held until the next accepted start.
REQ-010 busy  output  1  high in TEST and VERIFY.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 found  output  1  Eq was observed for the returned Result.
REQ-013 err  output  1  comparator flags were not one-hot when sampled.

Function
REQ-014 Search space: full signed range -2^(WIDTH-1) .. 2^(WIDTH-1)-1, using an internal offset-binary code register; Trial = code with MSB inverted.
REQ-015 States: IDLE, TEST, VERIFY, DONE; TEST holds a bit index k (WIDTH-1 down to 0).
REQ-016 IDLE: start=1 -> code <= 1 followed by zeros (Trial=0), k <= WIDTH-1, clear found/err, go to TEST; start=0 -> stay.
REQ-017 Trial SHALL be driven combinationally from the code register; flags are sampled on the edge ending each TEST/VERIFY cycle (one trial per cycle).
REQ-018 TEST, flags not one-hot (none or more than one set) -> err <= 1, found <= 0, Result <= Trial, go to DONE.
REQ-019 TEST, Eq=1 -> Result <= Trial, found <= 1, go to DONE (early termination).
REQ-020 TEST, Lt=1 -> clear code bit k; Gt=1 -> keep bit k.
REQ-021 TEST, no early exit: k>0 -> set code bit k-1, k <= k-1, stay in TEST; k=0 -> go to VERIFY.
REQ-022 VERIFY: Result <= Trial; found <= Eq; err <= 1 if flags not one-hot; go to DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; start asserted in DONE is ignored.
REQ-024 start while busy SHALL be ignored, with no effect on the search in progress.
REQ-025 Latency: done asserts at most WIDTH+2 cycles after the start edge (WIDTH TEST cycles + 1 VERIFY cycle + 1 DONE cycle); it is shorter on an early Eq.
REQ-026 In IDLE and DONE, Trial holds its last value; Result/found/err hold until the next accepted start.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and clear code and k; Trial reads -2^(WIDTH-1) (code all zeros); Result, busy, done, found, err all read 0.
REQ-028 Reset asserted mid-search SHALL abort the search with no done pulse; the first start after rst_n rises begins a fresh search.

Verification (WIDTH=4)
REQ-029 A=5, start -> Trial sequence 0,4,6,5; Eq at 5 -> done on cycle 5, Result=5, found=1, err=0.
REQ-030 A=-8 -> Trial 0,-4,-6,-7 (all Lt), VERIFY at -8 with Eq -> Result=-8, found=1; done on cycle 6.
REQ-031 A=-1 -> Trial 0,-4,-2,-1 -> Result=-1, found=1; A=7 -> Trial 0,4,6,7 -> Result=7, found=1.
REQ-032 Comparator held at Gt=Lt=1 on the first trial -> DONE next cycle, err=1, found=0, Result=0.
REQ-033 A second start pulsed while busy does not change the Trial sequence; rst_n pulsed low during TEST returns to IDLE with outputs zeroed and no done pulse.
REQ-034 Stuck comparator, Gt=1 always -> Trial 0,4,6,7, VERIFY at 7 with Eq=0 -> Result=7, found=0, err=0.
